// File: rtl/gpu_host_driver.sv
// Host initiator for the card command port: turns write/read/launch requests into instr/arg sequences.
// Latency: write rsp in C2, read rsp in C(RD_LATENCY+1), launch rsp one cycle after halt rises.
// Backpressure: cmd_ready only while idle; rsp is a single-beat pulse with no backpressure.
module gpu_host_driver #(
    parameter int RD_LATENCY     = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] cpu_recv_instr,
    output logic [31:0] cpu_in_data,
    input  logic [31:0] cpu_out_data,
    input  logic        gpu_halt
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WR_DATA, RD_WAIT, LN_LOW, LN_HIGH, RESP
    } state_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] data;
    } req_t;

    localparam logic [1:0]  OP_WR  = 2'd0;
    localparam logic [1:0]  OP_RD  = 2'd1;
    localparam logic [1:0]  OP_RSV = 2'd3;
    localparam logic [31:0] RD_LAT = 32'(RD_LATENCY);
    localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic [31:0] cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] in_data_q, in_data_d;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = 32'd0;
        instr_d     = 32'd0;
        in_data_d   = 32'd0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    req_d.op   = cmd_op;
                    req_d.data = cmd_data;
                    if (cmd_op == OP_RSV) begin
                        // Reserved ops never reach the card; answer with an error at once.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d   = ISSUE;
                        instr_d   = {30'd0, cmd_op} + 32'd1;
                        in_data_d = cmd_addr;
                    end
                end
            end
            ISSUE: begin
                cnt_d = 32'd1;
                case (req_q.op)
                    OP_WR: begin
                        state_d   = WR_DATA;
                        in_data_d = req_q.data;
                    end
                    OP_RD:   state_d = RD_WAIT;
                    default: state_d = LN_LOW;
                endcase
            end
            WR_DATA: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RD_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == RD_LAT) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = cpu_out_data;
                end
            end
            LN_LOW: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == TO_LIM) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = TO_LIM;
                end else if (!gpu_halt) begin
                    state_d = LN_HIGH;
                end
            end
            LN_HIGH: begin
                cnt_d = cnt_q + 32'd1;
                // Completion is checked first so a halt on the limit cycle still succeeds.
                if (gpu_halt) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = cnt_q;
                end else if (cnt_q == TO_LIM) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = TO_LIM;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cnt_q       <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'd0;
            instr_q     <= 32'd0;
            in_data_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            instr_q     <= instr_d;
            in_data_q   <= in_data_d;
        end
    end

    assign cmd_ready      = (state_q == IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_data       = rsp_data_q;
    assign cpu_recv_instr = instr_q;
    assign cpu_in_data    = in_data_q;

endmodule

// File: tb/tb_gpu_host_driver.sv
// Bench for gpu_host_driver: directed write/read/launch/timeout/reserved/reset cases plus a short random loop,
// with responses checked through an expected-response queue (data, err, cycle of arrival).
module tb_gpu_host_driver;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] cpu_recv_instr;
    logic [31:0] cpu_in_data;
    logic [31:0] cpu_out_data;
    logic        gpu_halt;

    gpu_host_driver #(.RD_LATENCY(2), .TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_addr       (cmd_addr),
        .cmd_data       (cmd_data),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .cpu_recv_instr (cpu_recv_instr),
        .cpu_in_data    (cpu_in_data),
        .cpu_out_data   (cpu_out_data),
        .gpu_halt       (gpu_halt)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Response monitor: every pulse must match the head of the queue, including its cycle.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic push_exp(input logic [31:0] d, input logic e, input int c);
        exp_t x;
        x.data = d;
        x.err  = e;
        x.cyc  = c;
        sb.push_back(x);
    endtask

    // Waits (bounded) for ready, presents one request, returns the cycle number of C0.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d, output int c0);
        int n;
        n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_addr  = 32'd0;
        cmd_data  = 32'd0;
        c0 = cyc;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        int c0;
        issue(2'd0, a, d, c0);
        push_exp(32'd0, 1'b0, c0 + 2);
        @(negedge clk);
        chk("wr_c0_instr", cpu_recv_instr, 32'd1);
        chk("wr_c0_arg", cpu_in_data, a);
        @(negedge clk);
        chk("wr_c1_instr", cpu_recv_instr, 32'd0);
        chk("wr_c1_arg", cpu_in_data, d);
        @(negedge clk);
        chk("wr_c2_ready", {31'd0, cmd_ready}, 32'd0);
        chk("wr_c2_arg", cpu_in_data, 32'd0);
        @(negedge clk);
        chk("wr_c3_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] v);
        int c0;
        issue(2'd1, a, JUNK, c0);
        push_exp(v, 1'b0, c0 + 3);
        @(negedge clk);
        chk("rd_c0_instr", cpu_recv_instr, 32'd2);
        chk("rd_c0_arg", cpu_in_data, a);
        cpu_out_data = JUNK;
        @(negedge clk);
        chk("rd_c1_instr", cpu_recv_instr, 32'd0);
        cpu_out_data = JUNK ^ 32'h1;
        @(negedge clk);
        cpu_out_data = v;
        @(negedge clk);
        cpu_out_data = JUNK ^ 32'h2;
        chk("rd_c3_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("rd_c4_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    // Launch with halt low in C1..C(rise-1) and high from C(rise) on.
    task automatic do_launch(input logic [31:0] pc, input int rise, input logic [31:0] exp_d,
                             input logic exp_e, input int rsp_c);
        int c0;
        gpu_halt = 1'b1;
        issue(2'd2, pc, JUNK, c0);
        push_exp(exp_d, exp_e, c0 + rsp_c);
        @(negedge clk);
        chk("ln_c0_instr", cpu_recv_instr, 32'd3);
        chk("ln_c0_arg", cpu_in_data, pc);
        for (int k = 1; k <= rsp_c + 1; k++) begin
            @(negedge clk);
            if (k == 1) gpu_halt = 1'b0;
            if (rise > 0 && k == rise) gpu_halt = 1'b1;
            if (k == 2) chk("ln_c2_instr", cpu_recv_instr, 32'd0);
        end
        chk("ln_ready_after", {31'd0, cmd_ready}, 32'd1);
        gpu_halt = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst          = 1'b1;
        cmd_valid    = 1'b1;
        cmd_op       = 2'd3;
        cmd_addr     = 32'h55;
        cmd_data     = 32'h77;
        cpu_out_data = JUNK;
        gpu_halt     = 1'b1;
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_instr", cpu_recv_instr, 32'd0);
        chk("rst_arg", cpu_in_data, 32'd0);

        do_write(32'h40, 32'hDEADBEEF);
        do_read(32'h40, 32'h12345678);
        do_launch(32'h100, 5, 32'd5, 1'b0, 6);
        do_launch(32'h200, 0, 32'd8, 1'b1, 9);
        do_launch(32'h300, 8, 32'd8, 1'b0, 9);

        issue(2'd3, 32'h55, 32'h77, c0);
        push_exp(32'd0, 1'b1, c0);
        @(negedge clk);
        chk("rsv_c0_instr", cpu_recv_instr, 32'd0);
        chk("rsv_c0_arg", cpu_in_data, 32'd0);
        @(negedge clk);
        chk("rsv_c1_instr", cpu_recv_instr, 32'd0);
        chk("rsv_c1_ready", {31'd0, cmd_ready}, 32'd1);

        // Abort a read with reset in C1; no response may follow.
        issue(2'd1, 32'h40, JUNK, c0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_instr", cpu_recv_instr, 32'd0);
        chk("abort_arg", cpu_in_data, 32'd0);
        chk("abort_rsp_data", rsp_data, 32'd0);
        repeat (4) @(negedge clk);
        do_write(32'h44, 32'hCAFEF00D);

        for (int i = 0; i < 4; i++) begin
            do_write($urandom, $urandom);
            do_read($urandom, $urandom);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
